// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the round-robin shared signed multiplier.
//   state_e         : arbiter FSM states (IDLE, CALC, RESP)
//   DEFAULT_SIZE    : default operand width in bits
//   DEFAULT_NUM_REQ : default number of requesters
package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } state_e;

  localparam int unsigned DEFAULT_SIZE    = 16;
  localparam int unsigned DEFAULT_NUM_REQ = 4;

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Request/response bus of the shared multiplier.
//   req_valid/req_ready : per-requester handshake, req_ready is a one-hot grant
//   req_a/req_b         : per-requester signed operands
//   rsp_valid/rsp_ready : result handshake
//   rsp_product/rsp_id  : signed product and the index of its owner
//   busy                : arbiter not in IDLE
// master = requesters + result consumer, slave = arbiter.
interface mult_share_arbiter_if
  import mult_arb_pkg::*;
#(
  parameter int unsigned SIZE    = DEFAULT_SIZE,
  parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0][SIZE-1:0] req_a;
  logic [NUM_REQ-1:0][SIZE-1:0] req_b;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [2*SIZE-1:0]            rsp_product;
  logic [ID_W-1:0]              rsp_id;
  logic                         busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_product, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_product, rsp_id, busy
  );

endinterface

// File: rtl/mult_share_arbiter_booth.sv
// Combinational radix-2 Booth multiplier, two's-complement signed.
//   a       : SIZE-bit signed multiplicand
//   b       : SIZE-bit signed multiplier
//   product : full 2*SIZE-bit signed product (no truncation)
module Booth_Multiplier
  import mult_arb_pkg::*;
#(
  parameter int unsigned SIZE = DEFAULT_SIZE
) (
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic [2*SIZE-1:0] product
);

  logic [2*SIZE-1:0] a_ext;
  logic [SIZE:0]     b_ext;

  // Each adjacent pair {b[i], b[i-1]} recodes to -1/0/+1 times a<<i;
  // b[-1] is the implicit zero appended below the LSB.
  always_comb begin
    a_ext   = {{SIZE{a[SIZE-1]}}, a};
    b_ext   = {b, 1'b0};
    product = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      case (b_ext[i +: 2])
        2'b01:   product = product + (a_ext << i);
        2'b10:   product = product - (a_ext << i);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one signed multiplier among NUM_REQ requesters.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mult_share_arbiter_if (request/response handshakes,
//           operands, product, owner id, busy)
// Flow: IDLE grants one requester (combinational one-hot req_ready) and
// latches its operands, CALC registers the product, RESP holds it until
// rsp_ready. One operation per three cycles at best.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned SIZE    = DEFAULT_SIZE,
  parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mult_share_arbiter_if.slave  bus
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  // First requester at or after ptr, searching circularly.
  function automatic logic [ID_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] valid,
    input logic [ID_W-1:0]    ptr
  );
    logic [ID_W-1:0] pick;
    logic            found;
    int unsigned     idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      if (!found && valid[ID_W'(idx)]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  state_e            state_q,       state_d;
  logic [ID_W-1:0]   rr_ptr_q,      rr_ptr_d;
  logic [ID_W-1:0]   id_q,          id_d;
  logic [SIZE-1:0]   a_q,           a_d;
  logic [SIZE-1:0]   b_q,           b_d;
  logic [2*SIZE-1:0] rsp_product_q, rsp_product_d;
  logic [ID_W-1:0]   rsp_id_q,      rsp_id_d;
  logic              rsp_valid_q,   rsp_valid_d;
  logic              busy_q,        busy_d;

  logic              any_req;
  logic [ID_W-1:0]   grant_idx;
  logic [2*SIZE-1:0] mult_out;

  assign any_req   = |bus.req_valid;
  assign grant_idx = rr_pick(bus.req_valid, rr_ptr_q);

  // The grant is offered only to a valid requester, so a granted IDLE
  // cycle is always a completed handshake. Gated by rst_n so the strobe
  // stays low throughout reset.
  assign bus.req_ready = (rst_n && (state_q == IDLE) && any_req)
                         ? (NUM_REQ'(1) << grant_idx) : '0;

  Booth_Multiplier #(.SIZE(SIZE)) u_booth (
    .a       (a_q),
    .b       (b_q),
    .product (mult_out)
  );

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
    a_d           = a_q;
    b_d           = b_q;
    rsp_product_d = rsp_product_q;
    rsp_id_d      = rsp_id_q;
    rsp_valid_d   = rsp_valid_q;
    busy_d        = busy_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          a_d      = bus.req_a[grant_idx];
          b_d      = bus.req_b[grant_idx];
          id_d     = grant_idx;
          rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d  = CALC;
          busy_d   = 1'b1;
        end
      end
      CALC: begin
        rsp_product_d = mult_out;
        rsp_id_d      = id_q;
        rsp_valid_d   = 1'b1;
        state_d       = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      id_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      rsp_product_q <= '0;
      rsp_id_q      <= '0;
      rsp_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      id_q          <= id_d;
      a_q           <= a_d;
      b_q           <= b_d;
      rsp_product_q <= rsp_product_d;
      rsp_id_q      <= rsp_id_d;
      rsp_valid_q   <= rsp_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_product = rsp_product_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter (SIZE=16, NUM_REQ=4).
// Expected responses are queued at each observed handshake and compared
// when the response handshake completes.
module tb_mult_share_arbiter;

  logic clk;
  logic rst_n;

  mult_share_arbiter_if #(.SIZE(16), .NUM_REQ(4)) bus ();

  mult_share_arbiter #(.SIZE(16), .NUM_REQ(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] prod;
  } exp_t;

  exp_t scb[$];
  int   grant_log[$];
  int   grant_cyc[$];
  int   cyc;
  int   checks;
  int   errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at the falling edge, return 1 ns after
  // the next rising edge.
  task automatic cycle();
    exp_t              e;
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    logic signed [31:0] p;
    @(negedge clk);
    chk("req_ready_onehot0", 64'($onehot0(bus.req_ready)), 64'd1);
    for (int i = 0; i < 4; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        sa     = bus.req_a[i];
        sb     = bus.req_b[i];
        p      = sa * sb;
        e.id   = i;
        e.prod = p;
        scb.push_back(e);
        grant_log.push_back(i);
        grant_cyc.push_back(cyc);
      end
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (scb.size() == 0) begin
        chk("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
      end else begin
        e = scb.pop_front();
        chk("sb_product", 64'(bus.rsp_product), 64'(e.prod));
        chk("sb_id", 64'(bus.rsp_id), 64'(e.id));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    #1;
    scb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Single isolated operation by requester id, rsp_ready held high.
  task automatic do_op(input int id, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp_prod);
    bus.req_valid[id] = 1'b1;
    bus.req_a[id]     = a;
    bus.req_b[id]     = b;
    #1;
    chk("op_grant", 64'(bus.req_ready), 64'(1) << id);
    cycle();
    bus.req_valid[id] = 1'b0;
    chk("op_calc_busy", 64'(bus.busy), 64'd1);
    chk("op_calc_no_rsp", 64'(bus.rsp_valid), 64'd0);
    cycle();
    chk("op_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("op_product", 64'(bus.rsp_product), 64'(exp_prod));
    chk("op_id", 64'(bus.rsp_id), 64'(id));
    cycle();
    chk("op_done_valid", 64'(bus.rsp_valid), 64'd0);
    chk("op_done_busy", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int n;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    checks = 0;
    errors = 0;
    cyc    = 0;

    // Reset state, with every request raised to show req_ready is gated.
    rst_n         = 1'b0;
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    #2;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_product", 64'(bus.rsp_product), 64'd0);
    chk("rst_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle", 64'(bus.busy), 64'd0);

    // Basic and signed operations, rr pointer walking 0..3 then back to 0.
    do_op(0, 16'd100, 16'd12, 32'd1200);
    do_op(1, 16'hFFFD, 16'd7, 32'hFFFF_FFEB);
    do_op(2, 16'd0, 16'd5, 32'd0);
    do_op(3, 16'h8000, 16'h8000, 32'h4000_0000);
    do_op(0, 16'h8000, 16'h7FFF, 32'hC000_8000);

    // All four requesting continuously from a fresh pointer.
    do_reset();
    bus.req_a     = {16'h8001, 16'd7, 16'hFF9C, 16'd1000};
    bus.req_b     = {16'd3, 16'hFFF9, 16'd250, 16'd33};
    bus.req_valid = 4'b1111;
    grant_log.delete();
    grant_cyc.delete();
    n = 0;
    while (grant_log.size() < 5 && n < 40) begin
      cycle();
      n++;
    end
    bus.req_valid = '0;
    chk("rr_grant_count", 64'(grant_log.size()), 64'd5);
    for (int k = 0; k < grant_log.size() && k < 5; k++) begin
      chk("rr_order", 64'(grant_log[k]), 64'(exp_order[k]));
      if (k > 0) chk("rr_spacing", 64'(grant_cyc[k] - grant_cyc[k-1]), 64'd3);
    end
    n = 0;
    while (scb.size() > 0 && n < 20) begin
      cycle();
      n++;
    end
    chk("rr_drain", 64'(scb.size()), 64'd0);

    // Backpressure with req2 pending behind req1.
    bus.rsp_ready = 1'b0;
    bus.req_a[1]  = 16'd300;
    bus.req_b[1]  = 16'hFFFE;
    bus.req_a[2]  = 16'd11;
    bus.req_b[2]  = 16'd13;
    bus.req_valid = 4'b0110;
    #1;
    chk("bp_grant1", 64'(bus.req_ready), 64'b0010);
    cycle();
    bus.req_valid[1] = 1'b0;
    cycle();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp_product", 64'(bus.rsp_product), 64'h0000_0000_FFFF_FDA8);
      chk("bp_id", 64'(bus.rsp_id), 64'd1);
      chk("bp_no_grant", 64'(bus.req_ready), 64'd0);
      cycle();
    end
    bus.rsp_ready = 1'b1;
    cycle();
    chk("bp_grant2", 64'(bus.req_ready), 64'b0100);
    cycle();
    bus.req_valid = '0;
    n = 0;
    while (scb.size() > 0 && n < 20) begin
      cycle();
      n++;
    end
    chk("bp_drain", 64'(scb.size()), 64'd0);

    // Reset while 85*30 is in CALC.
    bus.req_a[0]  = 16'd85;
    bus.req_b[0]  = 16'd30;
    bus.req_valid = 4'b0001;
    #1;
    chk("rc_grant", 64'(bus.req_ready), 64'b0001);
    cycle();
    bus.req_valid = '0;
    chk("rc_in_calc", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rc_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rc_product", 64'(bus.rsp_product), 64'd0);
    chk("rc_id", 64'(bus.rsp_id), 64'd0);
    chk("rc_busy", 64'(bus.busy), 64'd0);
    chk("rc_req_ready", 64'(bus.req_ready), 64'd0);
    scb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rc_no_rsp", 64'(bus.rsp_valid), 64'd0);
      cycle();
    end
    bus.req_a[0]  = 16'd90;
    bus.req_b[0]  = 16'd4;
    bus.req_valid = 4'b1111;
    #1;
    chk("rc_ptr_zero", 64'(bus.req_ready), 64'b0001);
    cycle();
    bus.req_valid = '0;
    cycle();
    chk("rc_next_valid", 64'(bus.rsp_valid), 64'd1);
    chk("rc_next_product", 64'(bus.rsp_product), 64'd360);
    chk("rc_next_id", 64'(bus.rsp_id), 64'd0);
    cycle();
    chk("rc_drain", 64'(scb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
